// File: rtl/cvbs_sync_gen.sv
// rtl/cvbs_sync_gen.sv - PAL-timed progressive composite-video sync and level generator
//
// Walks a line/field raster and emits the 6-bit CVBS sample stream: sync tip,
// black/blanking, and active video clamped to BLACK_LEVEL..BLACK_LEVEL+VIDEO_SPAN.
// Stage 1 decodes the counters into a line region, stage 2 registers levels.
// Counter-to-sample latency is two ce cycles; pixel_req leads sample by one.
//
// Ports:
//   clk         - sample clock (24 MHz)
//   reset_n     - asynchronous active-low reset
//   ce          - clock enable, all state advances only when high
//   video[5:0]  - unsigned pixel value, sampled on ce cycles with pixel_req=1
//   pixel_req   - pixel request, one ce cycle ahead of the matching sample
//   sample[5:0] - CVBS level to the DAC path
//   hsync       - composite sync, active low, aligned with sample
//   vsync       - field sync, active low, aligned with sample
//   field_start - one-ce-cycle pulse on the first sample of line 0
//
// Optional feature: define CVBS_SERRATION_EN to split each vsync line into two
// serrated half-line broad pulses instead of one broad pulse per line.

module cvbs_sync_gen #(
    parameter int LINE_CLKS       = 1536,
    parameter int HSYNC_CLKS      = 113,
    parameter int BACKPORCH_CLKS  = 137,
    parameter int FRONTPORCH_CLKS = 40,
    parameter int LINES           = 312,
    parameter int VSYNC_LINES     = 3,
    parameter int BLANK_LINES     = 23,
    parameter int SYNC_LEVEL      = 0,
    parameter int BLACK_LEVEL     = 16,
    parameter int VIDEO_SPAN      = 24
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ce,
    input  logic [5:0] video,
    output logic       pixel_req,
    output logic [5:0] sample,
    output logic       hsync,
    output logic       vsync,
    output logic       field_start
);

    localparam logic [10:0] H_LAST        = 11'(LINE_CLKS - 1);
    localparam logic [10:0] H_SYNC_END    = 11'(HSYNC_CLKS);
    localparam logic [10:0] H_ACT_START   = 11'(HSYNC_CLKS + BACKPORCH_CLKS);
    localparam logic [10:0] H_ACT_END     = 11'(LINE_CLKS - FRONTPORCH_CLKS);
    localparam logic [10:0] H_BROAD_END   = 11'(LINE_CLKS - HSYNC_CLKS);
    localparam logic [10:0] V_LAST        = 11'(LINES - 1);
    localparam logic [10:0] V_SYNC_END    = 11'(VSYNC_LINES);
    localparam logic [10:0] V_VIDEO_START = 11'(BLANK_LINES);
`ifdef CVBS_SERRATION_EN
    localparam logic [10:0] H_HALF           = 11'(LINE_CLKS / 2);
    localparam logic [10:0] H_HALF_BROAD_END = 11'(LINE_CLKS / 2 - HSYNC_CLKS);
`endif

    localparam logic [5:0] LVL_SYNC  = 6'(SYNC_LEVEL);
    localparam logic [5:0] LVL_BLACK = 6'(BLACK_LEVEL);
    localparam logic [5:0] LVL_SPAN  = 6'(VIDEO_SPAN);

    typedef enum logic [2:0] {
        R_SYNC,
        R_BACKPORCH,
        R_ACTIVE,
        R_FRONTPORCH,
        R_BROAD_LO,
        R_BROAD_HI
    } region_t;

    logic [10:0] h_cnt;
    logic [10:0] v_cnt;

    region_t region, region_next;
    logic    pixel_req_next;
    logic    s1_hsync_n, s1_hsync_n_next;
    logic    s1_vsync_n;
    logic    s1_first;

    logic [5:0] level_next;
    logic [5:0] video_lim;
    logic [6:0] video_sum;

    // Raster counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (ce) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 11'd1;
            end else begin
                h_cnt <= h_cnt + 11'd1;
            end
        end
    end

    // Next-state decode: region of the current counter position
    always_comb begin
        region_next = R_FRONTPORCH;
        if (v_cnt < V_SYNC_END) begin
`ifdef CVBS_SERRATION_EN
            if ((h_cnt < H_HALF_BROAD_END) ||
                ((h_cnt >= H_HALF) && (h_cnt < H_BROAD_END)))
                region_next = R_BROAD_LO;
            else
                region_next = R_BROAD_HI;
`else
            if (h_cnt < H_BROAD_END)
                region_next = R_BROAD_LO;
            else
                region_next = R_BROAD_HI;
`endif
        end else if (h_cnt < H_SYNC_END) begin
            region_next = R_SYNC;
        end else if (h_cnt < H_ACT_START) begin
            region_next = R_BACKPORCH;
        end else if (h_cnt < H_ACT_END) begin
            region_next = R_ACTIVE;
        end else begin
            region_next = R_FRONTPORCH;
        end
        pixel_req_next  = (region_next == R_ACTIVE) && (v_cnt >= V_VIDEO_START);
        s1_hsync_n_next = !((region_next == R_SYNC) || (region_next == R_BROAD_LO));
    end

    // Stage 1 state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            region     <= R_FRONTPORCH;
            pixel_req  <= 1'b0;
            s1_hsync_n <= 1'b1;
            s1_vsync_n <= 1'b1;
            s1_first   <= 1'b0;
        end else if (ce) begin
            region     <= region_next;
            pixel_req  <= pixel_req_next;
            s1_hsync_n <= s1_hsync_n_next;
            s1_vsync_n <= !(v_cnt < V_SYNC_END);
            s1_first   <= (h_cnt == '0) && (v_cnt == '0);
        end
    end

    // Output decode; video is only looked at while a pixel is requested so
    // an undefined input outside the window never reaches sample
    always_comb begin
        video_lim  = (video > LVL_SPAN) ? LVL_SPAN : video;
        video_sum  = {1'b0, LVL_BLACK} + {1'b0, video_lim};
        level_next = LVL_BLACK;
        case (region)
            R_SYNC, R_BROAD_LO: level_next = LVL_SYNC;
            R_ACTIVE:           level_next = pixel_req ? video_sum[5:0] : LVL_BLACK;
            default:            level_next = LVL_BLACK;
        endcase
    end

    // Stage 2 output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sample      <= LVL_BLACK;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            field_start <= 1'b0;
        end else if (ce) begin
            sample      <= level_next;
            hsync       <= s1_hsync_n;
            vsync       <= s1_vsync_n;
            field_start <= s1_first;
        end
    end

endmodule

// File: tb/tb_cvbs_sync_gen.sv
// tb/tb_cvbs_sync_gen.sv - self-checking bench for cvbs_sync_gen on a reduced raster
module tb_cvbs_sync_gen;

    localparam int LINE  = 96;
    localparam int HS    = 8;
    localparam int BP    = 10;
    localparam int FP    = 6;
    localparam int LINES = 40;
    localparam int VS    = 3;
    localparam int BL    = 8;
    localparam int SYNCL = 0;
    localparam int BLACK = 16;
    localparam int SPAN  = 24;
    localparam int FIELD = LINE * LINES;
    localparam int ACT0  = HS + BP;
    localparam int ACT1  = LINE - FP;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       ce = 1'b0;
    logic [5:0] video = 6'd0;
    logic       pixel_req;
    logic [5:0] sample;
    logic       hsync;
    logic       vsync;
    logic       field_start;

    cvbs_sync_gen #(
        .LINE_CLKS(LINE), .HSYNC_CLKS(HS), .BACKPORCH_CLKS(BP), .FRONTPORCH_CLKS(FP),
        .LINES(LINES), .VSYNC_LINES(VS), .BLANK_LINES(BL),
        .SYNC_LEVEL(SYNCL), .BLACK_LEVEL(BLACK), .VIDEO_SPAN(SPAN)
    ) dut (
        .clk(clk), .reset_n(reset_n), .ce(ce), .video(video),
        .pixel_req(pixel_req), .sample(sample), .hsync(hsync),
        .vsync(vsync), .field_start(field_start)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int k = 0;
    int cyc = 0;
    int ce_div = 1;
    int last_fall = -1, hs_fall_c = -1, hs_rise_c = -1, vs_fall_c = -1, fs_last = -1;
    logic prev_hs = 1'b1, prev_vs = 1'b1, prev_fs = 1'b0;
    int req_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d time=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int hpos(input int p);
        return p % LINE;
    endfunction

    function automatic int vpos(input int p);
        return (p / LINE) % LINES;
    endfunction

    // Directed pixel pattern: 0, 10, 24, 63 repeating across the active window
    function automatic int vid_of(input int p);
        case ((hpos(p) - ACT0) & 3)
            0: return 0;
            1: return 10;
            2: return 24;
            default: return 63;
        endcase
    endfunction

    function automatic bit exp_pix(input int p);
        if (p < 0) return 1'b0;
        return (vpos(p) >= BL) && (hpos(p) >= ACT0) && (hpos(p) < ACT1);
    endfunction

    function automatic bit broad_low(input int h);
`ifdef CVBS_SERRATION_EN
        return (h < LINE / 2 - HS) || ((h >= LINE / 2) && (h < LINE - HS));
`else
        return h < LINE - HS;
`endif
    endfunction

    function automatic int exp_level(input int p);
        int v;
        int h;
        int vid;
        if (p < 0) return BLACK;
        v = vpos(p);
        h = hpos(p);
        if (v < VS) return broad_low(h) ? SYNCL : BLACK;
        if (h < HS) return SYNCL;
        if (exp_pix(p)) begin
            vid = vid_of(p);
            return BLACK + ((vid > SPAN) ? SPAN : vid);
        end
        return BLACK;
    endfunction

    function automatic int exp_hs(input int p);
        if (p < 0) return 1;
        if (vpos(p) < VS) return broad_low(hpos(p)) ? 0 : 1;
        return (hpos(p) >= HS) ? 1 : 0;
    endfunction

    function automatic int exp_vs(input int p);
        if (p < 0) return 1;
        return (vpos(p) < VS) ? 0 : 1;
    endfunction

    function automatic int exp_fs(input int p);
        if (p < 0) return 0;
        return (p % FIELD == 0) ? 1 : 0;
    endfunction

    function automatic int lit_clamp(input int i);
        case (i)
            0: return 16;
            1: return 26;
            2: return 40;
            default: return 40;
        endcase
    endfunction

    task automatic invalidate();
        last_fall = -1;
        hs_fall_c = -1;
        hs_rise_c = -1;
        vs_fall_c = -1;
        fs_last = -1;
    endtask

    task automatic measure(input int p);
        int bw;
`ifdef CVBS_SERRATION_EN
        bw = LINE / 2 - HS;
`else
        bw = LINE - HS;
`endif
        if (p >= 0) begin
            if (prev_hs && !hsync) begin
                if (last_fall >= 0 && vpos(p) > VS && hpos(p) == 0)
                    chk("hsync_period", cyc - last_fall, LINE * ce_div);
                if (hs_rise_c >= 0 && vpos(p) <= VS && !(vpos(p) == 0 && hpos(p) == 0))
                    chk("broad_high_width", cyc - hs_rise_c, HS * ce_div);
                last_fall = cyc;
                hs_fall_c = cyc;
            end
            if (!prev_hs && hsync) begin
                if (hs_fall_c >= 0) begin
                    if (vpos(p) >= VS)
                        chk("hsync_low_width", cyc - hs_fall_c, HS * ce_div);
                    else
                        chk("broad_low_width", cyc - hs_fall_c, bw * ce_div);
                end
                hs_rise_c = cyc;
            end
            if (prev_vs && !vsync) vs_fall_c = cyc;
            if (!prev_vs && vsync && vs_fall_c >= 0)
                chk("vsync_low_width", cyc - vs_fall_c, VS * LINE * ce_div);
            if (!prev_fs && field_start) begin
                if (fs_last >= 0) chk("field_period", cyc - fs_last, FIELD * ce_div);
                fs_last = cyc;
            end
        end
        prev_hs = hsync;
        prev_vs = vsync;
        prev_fs = field_start;
    endtask

    // One clock: drive ce, advance the model on ce edges, present the next
    // pixel, then compare every output against the raster model
    task automatic step(input logic ce_v);
        int p;
        int q;
        ce = ce_v;
        @(posedge clk);
        cyc++;
        if (ce_v && reset_n) k++;
        #1;
        if (exp_pix(k - 1)) video = 6'(vid_of(k - 1));
        else video = 6'($urandom_range(0, 63));
        #2;
        p = k - 2;
        chk("pixel_req", int'(pixel_req), int'(exp_pix(k - 1)));
        chk("sample", int'(sample), exp_level(p));
        chk("hsync", int'(hsync), exp_hs(p));
        chk("vsync", int'(vsync), exp_vs(p));
        chk("field_start", int'(field_start), exp_fs(p));
        if (p >= 0 && vpos(p) == 20 && hpos(p) >= ACT0 && hpos(p) < ACT0 + 4)
            chk("clamp_literal", int'(sample), lit_clamp(hpos(p) - ACT0));
        if (p >= 0 && vpos(p) == 5 && hpos(p) >= HS)
            chk("blank_line_sample", int'(sample), 16);
        if (ce_v && reset_n) begin
            q = k - 1;
            if (q >= 0 && (vpos(q) == 20 || vpos(q) == 5)) begin
                if (hpos(q) == 0) req_cnt = 0;
                req_cnt += int'(pixel_req);
                if (hpos(q) == LINE - 1)
                    chk(vpos(q) == 20 ? "req_per_video_line" : "req_per_blank_line",
                        req_cnt, vpos(q) == 20 ? 72 : 0);
            end
        end
        measure(p);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_sample"}, int'(sample), 16);
        chk({tag, "_hsync"}, int'(hsync), 1);
        chk({tag, "_vsync"}, int'(vsync), 1);
        chk({tag, "_pixel_req"}, int'(pixel_req), 0);
        chk({tag, "_field_start"}, int'(field_start), 0);
    endtask

    initial begin
        bit hit;
        #2 reset_n = 1'b0;
        #1 check_reset_values("reset");
        step(1'b1);
        step(1'b1);
        check_reset_values("reset_held");
        #1 reset_n = 1'b1;
        k = 0;

        // Two full fields with ce held high
        for (int i = 0; i < 2 * FIELD + 20; i++) step(1'b1);

        // ce every other clock: all periods double
        ce_div = 2;
        invalidate();
        for (int i = 0; i < 2 * (2 * FIELD + 2 * LINE); i++) step(1'(i % 2 == 0));

        // Asynchronous reset mid-line on a video line
        ce_div = 1;
        invalidate();
        hit = 1'b0;
        for (int i = 0; i < FIELD + 10 && !hit; i++) begin
            step(1'b1);
            if ((k - 2) % FIELD == 25 * LINE + 50) hit = 1'b1;
        end
        chk("reset_point_reached", int'(hit), 1);
        reset_n = 1'b0;
        #1 check_reset_values("midline_reset");
        k = 0;
        invalidate();
        step(1'b1);
        step(1'b1);
        #1 reset_n = 1'b1;
        step(1'b1);
        chk("fs_after_1st_ce", int'(field_start), 0);
        step(1'b1);
        chk("fs_after_2nd_ce", int'(field_start), 1);
        step(1'b1);
        chk("fs_after_3rd_ce", int'(field_start), 0);
        for (int i = 0; i < 4 * LINE; i++) step(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
